rtc_bus_ctrl: RTL and testbench

RTC_BUS_CTRL -- requirements
Module: rtc_bus_ctrl

---
 rtl/rtc_bus_ctrl.sv | 135 +++++++++++++
 tb/tb_rtc_bus_ctrl.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rtc_bus_ctrl.sv
// RTC multiplexed-bus controller: micro register port in, six-phase A/D bus cycle out.
// Each non-idle phase lasts T_PHASE clocks; all bus outputs are registered.
module rtc_bus_ctrl #(
   parameter int unsigned T_PHASE = 10
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] dir,
   input  logic       act_rtc,
   input  logic       write_strobe,
   input  logic       read_strobe,
   input  logic [7:0] data_in,
   output logic [7:0] data_out,
   output logic       rtc_cs_n,
   output logic       rtc_rd_n,
   output logic       rtc_wr_n,
   output logic       rtc_ad,
   output logic [7:0] ad_out,
   output logic       ad_oe,
   input  logic [7:0] ad_in,
   output logic       busy
);

   typedef enum logic [2:0] {
      StIdle, StAddrSetup, StAddrHold, StGap, StDataSetup, StDataHold, StEnd
   } state_t;

   localparam logic [7:0] LastCnt = 8'(T_PHASE - 1);

   state_t     r_state, w_state_d;
   logic [7:0] r_cnt, w_cnt_d;
   logic [7:0] r_addr, r_wdata, r_rdata;
   logic       r_is_read, w_is_read_d;
   logic       w_wr_cmd, w_start, w_phase_done;
   logic       w_unused;

   // Read strobe carries no side effects; register reads are purely combinational.
   assign w_unused = read_strobe;

   always_comb begin
      w_wr_cmd     = write_strobe & act_rtc & ~busy;
      w_start      = w_wr_cmd & ((dir == 8'h01) | (dir == 8'h02));
      w_is_read_d  = w_start ? (dir == 8'h02) : r_is_read;
      w_phase_done = (r_cnt == LastCnt);
      w_state_d    = r_state;
      unique case (r_state)
         StIdle:      if (w_start)      w_state_d = StAddrSetup;
         StAddrSetup: if (w_phase_done) w_state_d = StAddrHold;
         StAddrHold:  if (w_phase_done) w_state_d = StGap;
         StGap:       if (w_phase_done) w_state_d = StDataSetup;
         StDataSetup: if (w_phase_done) w_state_d = StDataHold;
         StDataHold:  if (w_phase_done) w_state_d = StEnd;
         StEnd:       if (w_phase_done) w_state_d = StIdle;
         default:     w_state_d = StIdle;
      endcase
      w_cnt_d = (w_state_d != r_state || r_state == StIdle) ? 8'h00 : r_cnt + 8'h01;
   end

   always_comb begin
      data_out = 8'h00;
      if (act_rtc) begin
         if (dir == 8'h03)      data_out = {7'b0, busy};
         else if (dir == 8'h04) data_out = r_rdata;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state   <= StIdle;
         r_cnt     <= 8'h00;
         r_addr    <= 8'h00;
         r_wdata   <= 8'h00;
         r_rdata   <= 8'h00;
         r_is_read <= 1'b0;
         rtc_cs_n  <= 1'b1;
         rtc_rd_n  <= 1'b1;
         rtc_wr_n  <= 1'b1;
         rtc_ad    <= 1'b0;
         ad_out    <= 8'h00;
         ad_oe     <= 1'b0;
         busy      <= 1'b0;
      end else begin
         r_state   <= w_state_d;
         r_cnt     <= w_cnt_d;
         r_is_read <= w_is_read_d;
         if (w_wr_cmd && dir == 8'h00) r_addr  <= data_in;
         if (w_wr_cmd && dir == 8'h01) r_wdata <= data_in;
         // Capture on the edge that ends DATA_SETUP, where rd_n rises.
         if (r_state == StDataSetup && w_phase_done && r_is_read) r_rdata <= ad_in;

         // Outputs decoded from the next state so they change with the state register.
         rtc_cs_n <= 1'b1;
         rtc_rd_n <= 1'b1;
         rtc_wr_n <= 1'b1;
         rtc_ad   <= 1'b0;
         ad_out   <= 8'h00;
         ad_oe    <= 1'b0;
         busy     <= (w_state_d != StIdle);
         unique case (w_state_d)
            StAddrSetup: begin
               rtc_cs_n <= 1'b0;
               rtc_ad   <= 1'b1;
               rtc_wr_n <= 1'b0;
               ad_out   <= r_addr;
               ad_oe    <= 1'b1;
            end
            StAddrHold: begin
               rtc_cs_n <= 1'b0;
               rtc_ad   <= 1'b1;
               ad_out   <= r_addr;
               ad_oe    <= 1'b1;
            end
            StDataSetup: begin
               rtc_cs_n <= 1'b0;
               if (w_is_read_d) begin
                  rtc_rd_n <= 1'b0;
               end else begin
                  rtc_wr_n <= 1'b0;
                  ad_out   <= r_wdata;
                  ad_oe    <= 1'b1;
               end
            end
            StDataHold: begin
               rtc_cs_n <= 1'b0;
               if (!w_is_read_d) begin
                  ad_out <= r_wdata;
                  ad_oe  <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_rtc_bus_ctrl.sv
// Bench for rtc_bus_ctrl: T_PHASE=10 and T_PHASE=1 instances share stimulus and are checked
// every cycle against a transaction-timeline model, plus directed literal expectations.
module tb_rtc_bus_ctrl;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [7:0] dir = 8'h00;
   logic       act_rtc = 1'b0;
   logic       write_strobe = 1'b0;
   logic       read_strobe = 1'b0;
   logic [7:0] data_in = 8'h00;
   logic [7:0] ad_in = 8'h00;

   logic [7:0] data_out[2];
   logic [7:0] ad_out[2];
   logic       cs_n[2], rd_n[2], wr_n[2], rtc_ad[2], ad_oe[2], busy[2];

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   rtc_bus_ctrl #(.T_PHASE(10)) u_dut0 (
      .clk(clk), .reset(reset), .dir(dir), .act_rtc(act_rtc), .write_strobe(write_strobe),
      .read_strobe(read_strobe), .data_in(data_in), .data_out(data_out[0]),
      .rtc_cs_n(cs_n[0]), .rtc_rd_n(rd_n[0]), .rtc_wr_n(wr_n[0]), .rtc_ad(rtc_ad[0]),
      .ad_out(ad_out[0]), .ad_oe(ad_oe[0]), .ad_in(ad_in), .busy(busy[0])
   );

   rtc_bus_ctrl #(.T_PHASE(1)) u_dut1 (
      .clk(clk), .reset(reset), .dir(dir), .act_rtc(act_rtc), .write_strobe(write_strobe),
      .read_strobe(read_strobe), .data_in(data_in), .data_out(data_out[1]),
      .rtc_cs_n(cs_n[1]), .rtc_rd_n(rd_n[1]), .rtc_wr_n(wr_n[1]), .rtc_ad(rtc_ad[1]),
      .ad_out(ad_out[1]), .ad_oe(ad_oe[1]), .ad_in(ad_in), .busy(busy[1])
   );

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: a transaction is a 6*T timeline; phase index = elapsed / T.
   int         tp[2] = '{10, 1};
   bit         m_busy[2] = '{0, 0};
   int         m_el[2] = '{0, 0};
   bit         m_rd[2] = '{0, 0};
   logic [7:0] m_addr[2] = '{8'h00, 8'h00};
   logic [7:0] m_wdata[2] = '{8'h00, 8'h00};
   logic [7:0] m_rdata[2] = '{8'h00, 8'h00};

   always @(posedge clk or posedge reset) begin
      for (int i = 0; i < 2; i++) begin
         if (reset) begin
            m_busy[i] = 0; m_el[i] = 0; m_rd[i] = 0;
            m_addr[i] = 8'h00; m_wdata[i] = 8'h00; m_rdata[i] = 8'h00;
         end else if (m_busy[i]) begin
            if (m_rd[i] && m_el[i] == 4 * tp[i] - 1) m_rdata[i] = ad_in;
            if (m_el[i] == 6 * tp[i] - 1) m_busy[i] = 0;
            else m_el[i]++;
         end else if (write_strobe && act_rtc) begin
            if (dir == 8'h00) m_addr[i] = data_in;
            if (dir == 8'h01) begin
               m_wdata[i] = data_in; m_busy[i] = 1; m_el[i] = 0; m_rd[i] = 0;
            end
            if (dir == 8'h02) begin
               m_busy[i] = 1; m_el[i] = 0; m_rd[i] = 1;
            end
         end
      end
   end

   always @(posedge clk) begin
      #1;
      for (int i = 0; i < 2; i++) begin
         int p, e_cs, e_rd, e_wr, e_ad, e_oe, e_do;
         logic [7:0] e_out;
         p = m_busy[i] ? m_el[i] / tp[i] : -1;
         e_cs = 1; e_rd = 1; e_wr = 1; e_ad = 0; e_oe = 0; e_out = 8'h00;
         case (p)
            0: begin e_cs = 0; e_wr = 0; e_ad = 1; e_oe = 1; e_out = m_addr[i]; end
            1: begin e_cs = 0; e_ad = 1; e_oe = 1; e_out = m_addr[i]; end
            2: e_ad = -1;
            3: begin
               e_cs = 0;
               if (m_rd[i]) e_rd = 0;
               else begin e_wr = 0; e_oe = 1; e_out = m_wdata[i]; end
            end
            4: begin e_cs = 0; e_oe = m_rd[i] ? 0 : 1; e_out = m_wdata[i]; end
            5: e_ad = -1;
            default: ;
         endcase
         e_do = 0;
         if (act_rtc && dir == 8'h03) e_do = int'(m_busy[i]);
         if (act_rtc && dir == 8'h04) e_do = int'(m_rdata[i]);
         chk($sformatf("dut%0d busy", i), int'(busy[i]), int'(m_busy[i]));
         chk($sformatf("dut%0d cs_n", i), int'(cs_n[i]), e_cs);
         chk($sformatf("dut%0d rd_n", i), int'(rd_n[i]), e_rd);
         chk($sformatf("dut%0d wr_n", i), int'(wr_n[i]), e_wr);
         chk($sformatf("dut%0d ad_oe", i), int'(ad_oe[i]), e_oe);
         if (e_ad >= 0) chk($sformatf("dut%0d rtc_ad", i), int'(rtc_ad[i]), e_ad);
         if (e_oe == 1) chk($sformatf("dut%0d ad_out", i), int'(ad_out[i]), int'(e_out));
         chk($sformatf("dut%0d data_out", i), int'(data_out[i]), e_do);
         chk($sformatf("dut%0d rd_wr_excl", i), int'(rd_n[i] | wr_n[i]), 1);
      end
   end

   // Cycle counters for the literal expectations.
   int cnt_busy[2] = '{0, 0};
   int cnt_wrlow0 = 0, cnt_rdlow0 = 0, cnt_addr21 = 0, cnt_data45 = 0;
   always @(posedge clk) begin
      #1;
      if (busy[0]) cnt_busy[0]++;
      if (busy[1]) cnt_busy[1]++;
      if (!wr_n[0]) cnt_wrlow0++;
      if (!rd_n[0]) cnt_rdlow0++;
      if (!wr_n[0] && rtc_ad[0] && ad_oe[0] && ad_out[0] == 8'h21) cnt_addr21++;
      if (!wr_n[0] && !rtc_ad[0] && ad_oe[0] && ad_out[0] == 8'h45) cnt_data45++;
   end

   // Called at a negedge; strobe is sampled on the following posedge.
   task automatic wr(input logic [7:0] a, input logic [7:0] d);
      act_rtc = 1'b1; dir = a; data_in = d; write_strobe = 1'b1;
      @(negedge clk);
      write_strobe = 1'b0;
   endtask

   task automatic wait_idle(input int i, input int limit);
      int n = 0;
      while (busy[i] && n < limit) begin
         @(negedge clk);
         n++;
      end
      chk($sformatf("dut%0d wait_idle", i), int'(busy[i]), 0);
   endtask

   initial begin
      #100000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end

   initial begin
      int b_busy, b_wr, b_rd, b_a, b_d, n;
      repeat (2) @(negedge clk);
      act_rtc = 1'b1; dir = 8'h04;
      #1;
      chk("reset rdata", int'(data_out[0]), 0);
      chk("reset busy", int'(busy[0]), 0);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);

      // Write cycle
      wr(8'h00, 8'h21);
      b_busy = cnt_busy[0]; b_wr = cnt_wrlow0; b_a = cnt_addr21; b_d = cnt_data45;
      wr(8'h01, 8'h45);
      wait_idle(0, 100);
      chk("write busy cycles", cnt_busy[0] - b_busy, 60);
      chk("write wr_n low cycles", cnt_wrlow0 - b_wr, 20);
      chk("write addr phase 0x21", cnt_addr21 - b_a, 10);
      chk("write data phase 0x45", cnt_data45 - b_d, 10);

      // Read cycle
      wr(8'h00, 8'h22);
      ad_in = 8'h37;
      b_rd = cnt_rdlow0;
      wr(8'h02, 8'h00);
      wait_idle(0, 100);
      chk("read rd_n low cycles", cnt_rdlow0 - b_rd, 10);
      dir = 8'h04;
      #1;
      chk("read rdata dut0", int'(data_out[0]), 8'h37);
      chk("read rdata dut1", int'(data_out[1]), 8'h37);
      @(negedge clk);

      // Busy lockout
      b_busy = cnt_busy[0];
      wr(8'h01, 8'h55);
      repeat (15) @(negedge clk);
      wr(8'h01, 8'h99);
      dir = 8'h03;
      #1;
      chk("lockout status busy", int'(data_out[0]), 1);
      wait_idle(0, 100);
      #1;
      chk("lockout status idle", int'(data_out[0]), 0);
      chk("lockout busy cycles", cnt_busy[0] - b_busy, 60);
      wait_idle(1, 20);

      // Decode
      act_rtc = 1'b0; dir = 8'h01; data_in = 8'h77; write_strobe = 1'b1;
      @(negedge clk);
      write_strobe = 1'b0;
      repeat (2) @(negedge clk);
      chk("decode act0 busy dut0", int'(busy[0]), 0);
      chk("decode act0 busy dut1", int'(busy[1]), 0);
      act_rtc = 1'b1; dir = 8'h05;
      #1;
      chk("decode dir5 data_out", int'(data_out[0]), 0);
      @(negedge clk);

      // Reset in DATA_SETUP of a write
      wr(8'h00, 8'h10);
      wr(8'h01, 8'hAB);
      repeat (33) @(negedge clk);
      chk("pre-reset wr_n", int'(wr_n[0]), 0);
      reset = 1'b1;
      dir = 8'h04;
      #1;
      chk("reset cs_n", int'(cs_n[0]), 1);
      chk("reset wr_n", int'(wr_n[0]), 1);
      chk("reset ad_oe", int'(ad_oe[0]), 0);
      chk("reset busy mid", int'(busy[0]), 0);
      chk("reset rdata mid", int'(data_out[0]), 0);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      wr(8'h01, 8'h66);
      wait_idle(0, 100);
      wait_idle(1, 20);

      // T_PHASE=1 back-to-back
      b_busy = cnt_busy[1];
      wr(8'h01, 8'h12);
      n = 0;
      while (busy[1] && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("t1 first busy cycles", cnt_busy[1] - b_busy, 6);
      wr(8'h02, 8'h00);
      chk("t1 second accepted", int'(busy[1]), 1);
      wait_idle(1, 20);
      chk("t1 total busy cycles", cnt_busy[1] - b_busy, 12);
      wait_idle(0, 100);
      repeat (2) @(negedge clk);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
